cpu_bank_reg_mp: RTL

Parametrised multi-port register bank for the CPU core, successor to the single-write/dual-read bank. It provides NUM_READ combinational read ports, NUM_WRITE clocked write ports, an optional hardwired-zero register 0, and a per-register busy scoreboard. The issue stage sets busy bits and writeback clears them, so the decode stage can detect RAW hazards. It sits between decode (reads, issue) and writeback (writes).

---
 rtl/cpu_bank_reg_pkg.sv | 21 ++
 rtl/cpu_bank_reg_scoreboard.sv | 44 ++++
 rtl/cpu_bank_reg_mp.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_bank_reg_pkg.sv
// Shared constants, types and the write-port priority helper for the cpu_bank_reg_mp register bank.
// Optional forwarding is controlled by CPU_BANK_REG_BYPASS_EN (see cpu_bank_reg_mp).
package cpu_bank_reg_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_REGS   = 32;
    localparam int MAX_WRITE          = 8;

    typedef logic [$clog2(DEFAULT_NUM_REGS)-1:0] reg_addr_t;

    // Highest-index write port whose hit bit is set, or -1 when none hits.
    function automatic int hi_write_match(input logic [MAX_WRITE-1:0] hits);
        int idx;
        idx = -1;
        for (int i = 0; i < MAX_WRITE; i++) begin
            if (hits[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/cpu_bank_reg_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears (set wins), with a running popcount.
module cpu_bank_reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] set_i,
    input  logic [NUM_REGS-1:0] clr_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic [CNT_W-1:0]    count_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;

    assign busy_d = set_i | (busy_q & ~clr_i);

    // The counter tracks rising/falling bits so it always equals popcount(busy_q).
    always_comb begin
        count_d = count_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (busy_d[i] && !busy_q[i]) begin
                count_d = count_d + CNT_W'(1);
            end else if (!busy_d[i] && busy_q[i]) begin
                count_d = count_d - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o  = busy_q;
    assign count_o = count_q;

endmodule

// File: rtl/cpu_bank_reg_mp.sv
// Multi-port CPU register bank with busy scoreboard; define CPU_BANK_REG_BYPASS_EN to forward
// same-cycle write data to matching read ports.
module cpu_bank_reg_mp
    import cpu_bank_reg_pkg::*;
#(
    parameter  int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter  int NUM_REGS   = DEFAULT_NUM_REGS,
    parameter  int NUM_READ   = 2,
    parameter  int NUM_WRITE  = 2,
    parameter  int ZERO_REG   = 1,
    localparam int ADDR_W     = $clog2(NUM_REGS),
    localparam int CNT_W      = $clog2(NUM_REGS + 1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_READ*ADDR_W-1:0]    read_reg,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ-1:0]           read_busy,
    input  logic [NUM_WRITE-1:0]          write_enable,
    input  logic [NUM_WRITE*ADDR_W-1:0]   write_reg,
    input  logic [NUM_WRITE*DATA_WIDTH-1:0] write_data,
    input  logic                          issue_valid,
    input  logic [ADDR_W-1:0]             issue_reg,
    output logic [CNT_W-1:0]              busy_count
);

    localparam int WIDX_W = (NUM_WRITE > 1) ? $clog2(NUM_WRITE) : 1;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [ADDR_W-1:0]     waddr  [NUM_WRITE];
    logic [DATA_WIDTH-1:0] wdata  [NUM_WRITE];
    logic [WIDX_W-1:0]     wsel   [NUM_REGS];
    logic [NUM_REGS-1:0]   clr_vec, set_vec, busy_vec;

    genvar gi;

    for (gi = 0; gi < NUM_WRITE; gi++) begin : g_wr
        assign waddr[gi] = write_reg[gi*ADDR_W +: ADDR_W];
        assign wdata[gi] = write_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam bit HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
        logic [MAX_WRITE-1:0] hits;
        int                   sel;

        always_comb begin
            hits = '0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                hits[w] = write_enable[w] && (waddr[w] == ADDR_W'(gi));
            end
            sel = hi_write_match(hits);
        end

        assign wsel[gi]    = WIDX_W'(sel);
        assign clr_vec[gi] = (sel >= 0) && !HARD_ZERO;
        assign set_vec[gi] = issue_valid && (issue_reg == ADDR_W'(gi)) && !HARD_ZERO;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_vec[i]) regs_q[i] <= wdata[wsel[i]];
            end
        end
    end

    cpu_bank_reg_scoreboard #(
        .NUM_REGS(NUM_REGS),
        .CNT_W   (CNT_W)
    ) u_scoreboard (
        .clock  (clock),
        .reset  (reset),
        .set_i  (set_vec),
        .clr_i  (clr_vec),
        .busy_o (busy_vec),
        .count_o(busy_count)
    );

    for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
        logic [ADDR_W-1:0]     ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  rb;
`ifdef CPU_BANK_REG_BYPASS_EN
        logic [MAX_WRITE-1:0]  rhits;
        int                    rsel;
`endif

        assign ra = read_reg[gi*ADDR_W +: ADDR_W];

        always_comb begin
            rd = regs_q[ra];
            rb = busy_vec[ra];
`ifdef CPU_BANK_REG_BYPASS_EN
            rhits = '0;
            for (int w = 0; w < NUM_WRITE; w++) begin
                rhits[w] = write_enable[w] && (waddr[w] == ra);
            end
            rsel = hi_write_match(rhits);
            // A forwarded value is fresh, so it is only busy if a new producer issues now.
            if (rsel >= 0) begin
                rd = wdata[WIDX_W'(rsel)];
                rb = issue_valid && (issue_reg == ra);
            end
`endif
            if (reset || ((ZERO_REG != 0) && (ra == '0))) begin
                rd = '0;
                rb = 1'b0;
            end
        end

        assign read_data[gi*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign read_busy[gi]                          = rb;
    end

endmodule
